// File: rtl/beam_delay_align_prog_if.sv
// Bus bundle for the programmable beam delay aligner: sample stream in,
// delay-table programming port, aligned beams and status out.
interface beam_delay_align_prog_if #(
    parameter int NBEAMS = 2,
    parameter int NCHAN  = 8,
    parameter int NSAMP  = 4,
    parameter int NBITS  = 5,
    parameter int DEPTH  = 16
);
    localparam int MAXD = (DEPTH - 1) * NSAMP;
    localparam int DW   = $clog2(MAXD + 1);
    localparam int NENT = NBEAMS * NCHAN;
    localparam int AW   = (NENT > 1) ? $clog2(NENT) : 1;

    logic [NCHAN*NSAMP*NBITS-1:0]        data_i;
    logic                                valid_i;
    logic [AW-1:0]                       dly_addr_i;
    logic [DW-1:0]                       dly_dat_i;
    logic                                dly_wr_i;
    logic                                dly_update_i;
    logic [NBEAMS*NCHAN*NSAMP*NBITS-1:0] beams_o;
    logic                                beams_valid_o;
    logic                                dly_err_o;

    modport master (
        output data_i, valid_i, dly_addr_i, dly_dat_i, dly_wr_i, dly_update_i,
        input  beams_o, beams_valid_o, dly_err_o
    );

    modport slave (
        input  data_i, valid_i, dly_addr_i, dly_dat_i, dly_wr_i, dly_update_i,
        output beams_o, beams_valid_o, dly_err_o
    );
endinterface

// File: rtl/beam_delay_align_prog.sv
// Per-channel sample store with a double-buffered (shadow/active) delay table;
// every beam/channel lane picks NSAMP consecutive samples at its own delay.
module beam_delay_align_prog #(
    parameter int NBEAMS = 2,
    parameter int NCHAN  = 8,
    parameter int NSAMP  = 4,
    parameter int NBITS  = 5,
    parameter int DEPTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    beam_delay_align_prog_if.slave bus
);
    localparam int MAXD = (DEPTH - 1) * NSAMP;
    localparam int DW   = $clog2(MAXD + 1);
    localparam int NENT = NBEAMS * NCHAN;
    localparam int WW   = NSAMP * NBITS;
    localparam int FW   = $clog2(DEPTH + 1);
    localparam int BW   = NBEAMS * NCHAN * WW;

    typedef logic [WW-1:0] word_t;

    word_t           store_q [NCHAN][DEPTH];
    word_t           store_d [NCHAN][DEPTH];
    logic [DW-1:0]   shadow_q [NENT];
    logic [DW-1:0]   shadow_d [NENT];
    logic [DW-1:0]   act_q [NENT];
    logic [DW-1:0]   act_d [NENT];
    logic [FW-1:0]   fill_q, fill_d;
    logic            v1_q, v1_d;
    logic [BW-1:0]   beams_q, beams_d;
    logic            beams_valid_q, beams_valid_d;
    logic            err_q, err_d;

    logic                 fill_done;
    logic [31:0]          addr_ext, dat_ext;
    logic                 wr_ok, wr_bad;
    logic [DEPTH*WW-1:0]  flat;
    int                   idx;

    assign fill_done = (fill_q == FW'(DEPTH));

    // Store stage: store[c][0] is the newest word, store[c][DEPTH-1] the oldest.
    always_comb begin
        store_d = store_q;
        fill_d  = fill_q;
        v1_d    = bus.valid_i;
        if (bus.valid_i) begin
            for (int c = 0; c < NCHAN; c++) begin
                for (int w = DEPTH - 1; w > 0; w--) begin
                    store_d[c][w] = store_q[c][w-1];
                end
                store_d[c][0] = bus.data_i[c*WW +: WW];
            end
            if (!fill_done) fill_d = fill_q + FW'(1);
        end
    end

    always_comb begin
        addr_ext = 32'(bus.dly_addr_i);
        dat_ext  = 32'(bus.dly_dat_i);
        wr_ok    = bus.dly_wr_i && (addr_ext < NENT) && (dat_ext <= MAXD);
        wr_bad   = bus.dly_wr_i && !wr_ok;

        shadow_d = shadow_q;
        if (wr_ok) shadow_d[bus.dly_addr_i] = bus.dly_dat_i;

        // Committing from shadow_d lets a same-cycle legal write join the update.
        act_d = bus.dly_update_i ? shadow_d : act_q;

        err_d = err_q;
        if (bus.dly_update_i) err_d = 1'b0;
        if (wr_bad)           err_d = 1'b1;
    end

    // Output stage: flat places the oldest sample at index 0, so the sample
    // x[N*NSAMP+s-d] sits at flat index MAXD+s-d.
    always_comb begin
        beams_d       = beams_q;
        beams_valid_d = v1_q && fill_done;
        flat          = '0;
        idx           = 0;
        if (v1_q) begin
            for (int c = 0; c < NCHAN; c++) begin
                for (int w = 0; w < DEPTH; w++) begin
                    flat[(DEPTH-1-w)*WW +: WW] = store_q[c][w];
                end
                for (int b = 0; b < NBEAMS; b++) begin
                    for (int s = 0; s < NSAMP; s++) begin
                        idx = MAXD + s - int'(act_q[b*NCHAN+c]);
                        beams_d[((b*NCHAN+c)*NSAMP+s)*NBITS +: NBITS] = flat[idx*NBITS +: NBITS];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            store_q       <= '{default: '0};
            shadow_q      <= '{default: '0};
            act_q         <= '{default: '0};
            fill_q        <= '0;
            v1_q          <= 1'b0;
            beams_q       <= '0;
            beams_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            store_q       <= store_d;
            shadow_q      <= shadow_d;
            act_q         <= act_d;
            fill_q        <= fill_d;
            v1_q          <= v1_d;
            beams_q       <= beams_d;
            beams_valid_q <= beams_valid_d;
            err_q         <= err_d;
        end
    end

    assign bus.beams_o       = beams_q;
    assign bus.beams_valid_o = beams_valid_q;
    assign bus.dly_err_o     = err_q;

endmodule

// File: tb/tb_beam_delay_align_prog.sv
// Scoreboard bench for beam_delay_align_prog: directed stimulus pushes the
// expected aligned beams with their due cycle; a monitor pops and compares.
module tb_beam_delay_align_prog;
    localparam int NBEAMS = 2;
    localparam int NCHAN  = 8;
    localparam int NSAMP  = 4;
    localparam int NBITS  = 5;
    localparam int DEPTH  = 16;
    localparam int MAXD   = (DEPTH - 1) * NSAMP;
    localparam int DW     = $clog2(MAXD + 1);
    localparam int NENT   = NBEAMS * NCHAN;
    localparam int AW     = $clog2(NENT);
    localparam int DATW   = NCHAN * NSAMP * NBITS;
    localparam int BW     = NBEAMS * DATW;

    typedef struct {
        int            due;
        logic [BW-1:0] beams;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t exp_q[$];
    int   sh_m [NENT];
    int   act_m [NENT];
    int   fill_m;
    int   n_m;
    bit   err_m;

    beam_delay_align_prog_if bus ();

    beam_delay_align_prog dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Channel c carries the ramp offset by 5*c so that lanes are distinguishable.
    function automatic logic [DATW-1:0] ramp_word(int n);
        logic [DATW-1:0] w;
        w = '0;
        for (int c = 0; c < NCHAN; c++)
            for (int s = 0; s < NSAMP; s++)
                w[(c*NSAMP+s)*NBITS +: NBITS] = NBITS'((n*NSAMP + s + 5*c) & 31);
        return w;
    endfunction

    function automatic logic [BW-1:0] exp_beams(int n);
        logic [BW-1:0] v;
        v = '0;
        for (int b = 0; b < NBEAMS; b++)
            for (int c = 0; c < NCHAN; c++)
                for (int s = 0; s < NSAMP; s++)
                    v[((b*NCHAN+c)*NSAMP+s)*NBITS +: NBITS] =
                        NBITS'((n*NSAMP + s - act_m[b*NCHAN+c] + 5*c) & 31);
        return v;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin
            sh_m[i]  = 0;
            act_m[i] = 0;
        end
        fill_m = 0;
        err_m  = 1'b0;
        exp_q.delete();
    endtask

    // One clock of stimulus, driven just after the rising edge.
    task automatic step(input bit v, input bit wr = 0, input int addr = 0,
                        input int dat = 0, input bit upd = 0);
        bit legal;
        bus.valid_i      = v;
        bus.dly_wr_i     = wr;
        bus.dly_addr_i   = AW'(addr);
        bus.dly_dat_i    = DW'(dat);
        bus.dly_update_i = upd;
        legal = wr && (addr < NENT) && (dat <= MAXD);
        if (legal) sh_m[addr] = dat;
        if (upd) begin
            act_m = sh_m;
            err_m = 1'b0;
        end
        if (wr && !legal) err_m = 1'b1;
        if (v) begin
            bus.data_i = ramp_word(n_m);
            if (fill_m < DEPTH) fill_m++;
            if (fill_m == DEPTH) exp_q.push_back('{cyc + 2, exp_beams(n_m)});
            n_m++;
        end else begin
            bus.data_i = ramp_word(n_m + 9);
        end
        @(posedge clk);
        #1;
        chk("dly_err_o", BW'(bus.dly_err_o), BW'(err_m));
    endtask

    task automatic pulse_reset();
        bus.valid_i      = 1'b0;
        bus.dly_wr_i     = 1'b0;
        bus.dly_update_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_beams_o", bus.beams_o, '0);
        chk("rst_beams_valid_o", BW'(bus.beams_valid_o), '0);
        chk("rst_dly_err_o", BW'(bus.dly_err_o), '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_valid: got beams_valid_o=0 at cycle %0d expected 1", exp_q[0].due);
                    void'(exp_q.pop_front());
                end
                if (bus.beams_valid_o) begin
                    if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got beams_valid_o=1 at cycle %0d expected 0", cyc);
                    end else begin
                        chk("beams_o", bus.beams_o, exp_q.pop_front().beams);
                    end
                end
            end
        end
    end

    initial begin
        n_m = 0;
        model_reset();
        rst_n            = 1'b0;
        bus.data_i       = '0;
        bus.valid_i      = 1'b0;
        bus.dly_addr_i   = '0;
        bus.dly_dat_i    = '0;
        bus.dly_wr_i     = 1'b0;
        bus.dly_update_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_beams_o", bus.beams_o, '0);
        chk("init_beams_valid_o", BW'(bus.beams_valid_o), '0);
        chk("init_dly_err_o", BW'(bus.dly_err_o), '0);
        rst_n = 1'b1;

        // Fill with all delays zero; first valid output two cycles after the 16th word.
        repeat (22) step(1);

        // delay[1][3] = 5, committed by a later update.
        step(1, 1, 1*NCHAN + 3, 5);
        step(1, 0, 0, 0, 1);
        repeat (6) step(1);

        // Out-of-range delay: rejected, sticky error, cleared by the next update.
        step(1, 1, 5, 61);
        step(1);
        step(1, 0, 0, 0, 1);
        repeat (3) step(1);

        // Illegal write together with an update keeps the error set.
        step(1, 1, 2, 63, 1);
        step(1, 0, 0, 0, 1);

        // Same-cycle write and commit at the maximum delay; odd delay on another lane.
        step(1, 1, 0, MAXD, 1);
        repeat (4) step(1);
        step(1, 1, 1*NCHAN + 7, 33);
        step(1, 0, 0, 0, 1);
        repeat (4) step(1);

        // Gapped valid: store holds on idle cycles, alignment unchanged.
        repeat (4) begin
            step(1);
            step(0);
        end
        step(0);
        step(0);
        repeat (4) step(1);

        // Leave the error flag set, then reset mid-stream.
        step(1, 1, 4, 62);
        step(1);
        pulse_reset();
        repeat (20) step(1);
        step(1, 1, 6, 9, 1);
        repeat (4) step(1);

        repeat (4) step(0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending outputs expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish by 50000 expected finish");
        $fatal(1);
    end

endmodule
